// File: rtl/bsw_al_collector_if.sv
// ---------------------------------------------------------------------------
// bsw_al_collector_if
//
// Bundles the two streams that cross the collector boundary:
//   - the BSW alignment output stream (done, Q_al, R_al, detail_info),
//     driven by the aligner and consumed by the collector;
//   - the replay stream (out_valid, out_ready, out_q, out_r, out_last),
//     produced by the collector and accepted by downstream logic.
//
// Modports:
//   master : the environment side (aligner + downstream consumer)
//   slave  : the collector side
//
// Character coding on Q_al/R_al/out_q/out_r:
//   1=A 2=T 3=G 4=C 5=gap, 0=end of stream, 6/7 illegal.
// ---------------------------------------------------------------------------
interface bsw_al_collector_if #(
    parameter int SCORE_WIDTH = 9
);

    // BSW result stream
    logic                   done;
    logic [2:0]             Q_al;
    logic [2:0]             R_al;
    logic [SCORE_WIDTH-1:0] detail_info;

    // Replay stream
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             out_q;
    logic [2:0]             out_r;
    logic                   out_last;

    modport master (
        output done,
        output Q_al,
        output R_al,
        output detail_info,
        output out_ready,
        input  out_valid,
        input  out_q,
        input  out_r,
        input  out_last
    );

    modport slave (
        input  done,
        input  Q_al,
        input  R_al,
        input  detail_info,
        input  out_ready,
        output out_valid,
        output out_q,
        output out_r,
        output out_last
    );

endinterface

// File: rtl/bsw_al_collector.sv
// ---------------------------------------------------------------------------
// bsw_al_collector
//
// Receive-side endpoint of the BSW alignment output stream. Once the aligner
// raises done, the serial {Q_al,R_al} character stream is written into an
// internal buffer until a Q_al==0 terminator arrives (or the buffer fills).
// The first five detail_info words are latched as pos_info, word 4 being the
// alignment score, and every score is added into a running total. The stored
// alignment is then replayed downstream over a valid/ready stream.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   bus          bsw_al_collector_if.slave: input stream + replay stream
//   res_valid    result registers valid (high throughout DRAIN)
//   aln_len      number of captured beats
//   pos_info     five detail words, word k at [k*SCORE_WIDTH +: SCORE_WIDTH]
//   score        copy of pos_info word 4 taken at end of capture
//   total_score  sum of scores since reset or the last clr_total
//   clr_total    synchronous clear of total_score (wins over accumulate)
//   busy         high while collecting or replaying
//   err          an illegal character code was seen in the last capture
//   overflow     the last capture ran past the buffer depth
//
// The SCORE_WIDTH of the connected interface must match this module's.
// ---------------------------------------------------------------------------
module bsw_al_collector #(
    parameter int SIZE        = 64,
    parameter int SCORE_WIDTH = 9,
    parameter int LEN_W       = 8,
    parameter int ACC_W       = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    bsw_al_collector_if.slave        bus,
    output logic                     res_valid,
    output logic [LEN_W-1:0]         aln_len,
    output logic [5*SCORE_WIDTH-1:0] pos_info,
    output logic [SCORE_WIDTH-1:0]   score,
    output logic [ACC_W-1:0]         total_score,
    input  logic                     clr_total,
    output logic                     busy,
    output logic                     err,
    output logic                     overflow
);

    // Buffer depth is tied to the sequence length: a full alignment of two
    // SIZE-long sequences can never exceed 2*SIZE columns.
    localparam int               DEPTH   = 2 * SIZE;
    localparam int               AW      = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] rd_ptr;

    // Character buffer, one {Q,R} pair per entry. Contents are deliberately
    // not reset; the replay outputs are gated so stale data never leaks out.
    logic [5:0] buffer [DEPTH];

    logic                   beat_present;
    logic                   beat_illegal;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [5:0]             rd_data;
    logic                   out_valid_int;
    logic                   out_last_int;
    logic [SCORE_WIDTH-1:0] word4;

    // Classify the incoming beat. A nonzero query paired with a zero
    // reference is as invalid as codes 6/7, since the terminator is defined
    // by the query lane alone.
    always_comb begin
        beat_present = (bus.Q_al != 3'd0);
        beat_illegal = 1'b0;
        if (beat_present) begin
            beat_illegal = (bus.Q_al >= 3'd6) || (bus.R_al >= 3'd6) ||
                           (bus.R_al == 3'd0);
        end
    end

    // Buffer write side. Beat 0 is accepted straight out of IDLE so that no
    // cycle of the stream is lost; a beat arriving with the buffer full is
    // the overflow beat and is dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (state == IDLE) begin
            wr_en   = bus.done && beat_present;
            wr_addr = '0;
        end else if (state == COLLECT) begin
            wr_en   = beat_present && (count != DEPTH_L);
            wr_addr = count[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_addr] <= {bus.Q_al, bus.R_al};
        end
    end

    // Replay read side. Data is read combinationally at rd_ptr so that it
    // holds steady for as long as the consumer stalls.
    always_comb begin
        rd_data       = buffer[rd_ptr[AW-1:0]];
        out_valid_int = (state == DRAIN) && (rd_ptr < aln_len);
        out_last_int  = out_valid_int && (rd_ptr == aln_len - LEN_W'(1));
        word4         = pos_info[4*SCORE_WIDTH +: SCORE_WIDTH];
    end

    assign bus.out_valid = out_valid_int;
    assign bus.out_last  = out_last_int;
    assign bus.out_q     = out_valid_int ? rd_data[5:3] : 3'd0;
    assign bus.out_r     = out_valid_int ? rd_data[2:0] : 3'd0;

    // Control FSM with registered result/status outputs. The score added to
    // the running total is word 4 as it stands at termination; because the
    // terminating beat is never stored, word 4 is already final by then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            rd_ptr      <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            aln_len     <= '0;
            pos_info    <= '0;
            score       <= '0;
            total_score <= '0;
            err         <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (clr_total) begin
                total_score <= '0;
            end

            case (state)
                IDLE: begin
                    if (bus.done) begin
                        busy <= 1'b1;
                        if (beat_present) begin
                            pos_info                  <= '0;
                            pos_info[0 +: SCORE_WIDTH] <= bus.detail_info;
                            err                       <= beat_illegal;
                            overflow                  <= 1'b0;
                            count                     <= LEN_W'(1);
                            state                     <= COLLECT;
                        end else begin
                            // Empty alignment: nothing to replay, but the
                            // result registers still go valid for one cycle.
                            aln_len   <= '0;
                            score     <= '0;
                            rd_ptr    <= '0;
                            res_valid <= 1'b1;
                            state     <= DRAIN;
                        end
                    end
                end

                COLLECT: begin
                    if (!beat_present || (count == DEPTH_L)) begin
                        if (beat_present) begin
                            overflow <= 1'b1;
                        end
                        aln_len   <= count;
                        score     <= word4;
                        if (!clr_total) begin
                            total_score <= total_score + ACC_W'(word4);
                        end
                        rd_ptr    <= '0;
                        res_valid <= 1'b1;
                        state     <= DRAIN;
                    end else begin
                        for (int k = 0; k < 5; k++) begin
                            if (count == LEN_W'(k)) begin
                                pos_info[k*SCORE_WIDTH +: SCORE_WIDTH] <= bus.detail_info;
                            end
                        end
                        if (beat_illegal) begin
                            err <= 1'b1;
                        end
                        count <= count + LEN_W'(1);
                    end
                end

                DRAIN: begin
                    if (aln_len == '0) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        count     <= '0;
                        state     <= IDLE;
                    end else if (out_valid_int && bus.out_ready) begin
                        if (out_last_int) begin
                            rd_ptr    <= '0;
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            count     <= '0;
                            state     <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + LEN_W'(1);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
